ternary_weight_loader: RTL
==========================

Name: ternary_weight_loader

Overview:
- Parametrised successor to the single-bank ternary weight loader.
- Loads a MAX_IN_LEN x MAX_OUT_LEN array of 2-bit signed ternary weights column by column, two beats per column (MSB plane, then LSB plane), over a valid/ready stream.
- Writes into a shadow bank and commits atomically to the active bank that feeds the ternary MAC array, so compute never sees a partially loaded matrix.
- Adds programmable row/column extents, start/abort control and busy/done status.

Parameters:
- MAX_IN_LEN, 16, rows; the input word width. Power of 2, >=2.
- MAX_OUT_LEN, 8, columns. Power of 2, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a load; honoured only in IDLE
- abort  in  1  cancel a load in progress; the active bank is untouched
- cfg_last_row  in  $clog2(MAX_IN_LEN)  index of the last used row; sampled at start
- cfg_last_col  in  $clog2(MAX_OUT_LEN)  index of the last used column; sampled at start
- ui_input  in  MAX_IN_LEN  bit-plane word, bit i = row i
- in_valid  in  1  ui_input valid
- in_ready  out  1  loader accepts a beat
- uo_weights  out  2*MAX_IN_LEN*MAX_OUT_LEN  active bank; weight[r][c] at bits [2*(r*MAX_OUT_LEN+c)+1 : 2*(r*MAX_OUT_LEN+c)]
- uo_busy  out  1  state != IDLE
- uo_done  out  1  one-cycle pulse on commit
- uo_err  out  1  sticky invalid-code flag (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE; shadow and active banks all 00; col=0; in_ready=0, uo_done=0, uo_err=0, uo_busy=0.
- States: IDLE, MSB, LSB, COMMIT.
- IDLE:
  - start=1 captures cfg_last_row/cfg_last_col, clears col and uo_err, goes to MSB.
  - in_ready=0.
- MSB:
  - in_ready=1.
  - A beat is a transfer when in_valid & in_ready.
  - On a transfer: msb_q <= ui_input, go to LSB.
- LSB:
  - in_ready=1.
  - On a transfer: for every row i, shadow[i][col] <= (i <= last_row) ? {msb_q[i], ui_input[i]} : 2'b00.
  - If col == last_col, go to COMMIT; else col <= col+1 and go to MSB.
- COMMIT (one cycle):
  - active[r][c] <= (c <= last_col) ? shadow[r][c] : 2'b00.
  - uo_done=1 for exactly this cycle.
  - Next state IDLE.
  - New uo_weights are visible the cycle after COMMIT, i.e. two cycles after the final LSB beat.
- Encoding: 01=+1, 11=-1, 00=0, 10=invalid (-2).
- Beats with in_valid=0 stall with no state change. No timeout.
- abort=1 in MSB/LSB/COMMIT: next state IDLE, no commit, no done, active unchanged. Abort wins over a simultaneous final beat or COMMIT.
- start while busy: ignored, and cfg is not re-sampled.
- start and abort together in IDLE: abort has no effect; the load starts.
- cfg_last_col=0: a single column, two beats total.
- cfg_last_col=MAX_OUT_LEN-1: col reaches max with no wrap before COMMIT.
- Back-to-back: start may be asserted in the IDLE cycle after COMMIT. Shadow contents from the previous load are overwritten or masked, never leaked.

Optional Feature:
- Macro: LOAD_CODE_CHECK_EN.
- Defined:
  - An invalid code 10 on a used row is stored as 00 and sets uo_err.
  - uo_err is sticky until the next accepted start or reset.
  - Masked rows never set uo_err.
- Undefined: codes are stored raw (10 = -2) and uo_err is tied 0.

Decomposition:
- Package ternary_pkg:
  - typedef trit_t (logic signed [1:0]).
  - Constants TRIT_ZERO, TRIT_POS, TRIT_NEG, TRIT_INVALID.
  - Enum load_state_t {IDLE, MSB, LSB, COMMIT}.
- Sub-module ternary_weight_bank:
  - Holds the shadow and active arrays.
  - Ports: wr_en, wr_col, wr_data (row vector), commit, last_col mask, flattened active output.
  - The FSM, handshake and code check stay in the top module.

Test Plan:
- Full load, 16x8, all cfg at max: 16 beats alternating MSB=0xFFFF/LSB=0xFFFF for even cols and MSB=0/LSB=0xFFFF for odd cols -> done pulses 1 cycle after the 16th beat; weights = -1 in even cols, +1 in odd cols.
- Partial extent: last_row=3, last_col=1, MSB=0, LSB=0xFFFF -> rows 0-3 of cols 0-1 = +1; all other weights 00, including stale values from a prior full load.
- Backpressure: in_valid deasserted for 5 cycles mid-column -> no state change; final weights identical to the no-stall run.
- Abort on the final LSB beat of a load with all LSB=0xFFFF after a prior all-(+1) load -> no uo_done; uo_weights remain the prior matrix; uo_busy=0 next cycle.
- Reset mid-LSB -> in the same cycle all outputs are 0 and the state is IDLE; a subsequent start performs a clean load.
- With LOAD_CODE_CHECK_EN: MSB=0x0001, LSB=0x0000 on row 0 -> weight 00 and uo_err=1; the next start clears uo_err. Without the macro: weight 10 and uo_err=0.

Source files
------------

// File: rtl/ternary_pkg.sv
// Shared types and constants for the ternary weight loader.
// trit_t encoding: 01=+1, 11=-1, 00=0, 10=invalid (-2).
package ternary_pkg;

  typedef logic signed [1:0] trit_t;

  localparam trit_t TRIT_ZERO    = 2'sb00;
  localparam trit_t TRIT_POS     = 2'sb01;
  localparam trit_t TRIT_NEG     = 2'sb11;
  localparam trit_t TRIT_INVALID = 2'sb10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MSB    = 2'd1,
    LSB    = 2'd2,
    COMMIT = 2'd3
  } load_state_t;

  // True for the one code that has no ternary meaning.
  function automatic logic trit_is_invalid(input trit_t t);
    return t == TRIT_INVALID;
  endfunction

endpackage

// File: rtl/ternary_weight_bank.sv
// Shadow/active weight storage for the ternary weight loader.
// The shadow bank is written one column at a time. On commit, the active bank
// takes the shadow bank, and columns past last_col are forced to zero.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (clears both banks)
//   wr_en     write wr_data into shadow column wr_col
//   wr_col    shadow column index
//   wr_data   one trit per row, row r at [2r+1:2r]
//   commit    copy shadow -> active, masking columns > last_col
//   last_col  index of the last used column
//   active    flattened active bank, weight[r][c] at [2(r*COLS+c)+1 : 2(r*COLS+c)]
module ternary_weight_bank
  import ternary_pkg::*;
#(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(COLS)-1:0]    wr_col,
  input  logic [2*ROWS-1:0]          wr_data,
  input  logic                       commit,
  input  logic [$clog2(COLS)-1:0]    last_col,
  output logic [2*ROWS*COLS-1:0]     active
);

  localparam int unsigned COL_W = $clog2(COLS);

  trit_t shadow_q [ROWS][COLS];
  trit_t active_q [ROWS][COLS];

  // Shadow bank: column write from the loader.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          shadow_q[r][c] <= TRIT_ZERO;
        end
      end
    end else if (wr_en) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (COL_W'(c) == wr_col) begin
            shadow_q[r][c] <= trit_t'(wr_data[2*r +: 2]);
          end
        end
      end
    end
  end

  // Active bank: atomic commit. Masking here stops stale shadow columns from a
  // wider earlier load leaking into a narrower one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          active_q[r][c] <= TRIT_ZERO;
        end
      end
    end else if (commit) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          active_q[r][c] <= (COL_W'(c) <= last_col) ? shadow_q[r][c] : TRIT_ZERO;
        end
      end
    end
  end

  // Flatten the active bank row-major onto the output bus.
  always_comb begin
    active = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        active[2*(r*COLS+c) +: 2] = active_q[r][c];
      end
    end
  end

endmodule

// File: rtl/ternary_weight_loader.sv
// Ternary weight loader: streams a MAX_IN_LEN x MAX_OUT_LEN matrix of 2-bit
// ternary weights in column by column, two beats per column (MSB plane, then
// LSB plane). Loads go into a shadow bank and are committed atomically.
// Optional macro: LOAD_CODE_CHECK_EN. When it is defined, an invalid code (10)
// on a used row is stored as 00 and sets the sticky uo_err flag.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         begin a load (IDLE only); samples cfg_last_row/cfg_last_col
//   abort         cancel a load in progress; the active bank is left unchanged
//   cfg_last_row  index of the last used row
//   cfg_last_col  index of the last used column
//   ui_input      bit-plane word, bit i = row i
//   in_valid      ui_input valid
//   in_ready      loader accepts a beat (MSB/LSB states)
//   uo_weights    active bank, weight[r][c] at [2(r*MAX_OUT_LEN+c)+1 : 2(r*MAX_OUT_LEN+c)]
//   uo_busy       loader not idle
//   uo_done       one-cycle pulse during the commit cycle
//   uo_err        sticky invalid-code flag (always 0 without LOAD_CODE_CHECK_EN)
module ternary_weight_loader
  import ternary_pkg::*;
#(
  parameter int unsigned MAX_IN_LEN  = 16,
  parameter int unsigned MAX_OUT_LEN = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [$clog2(MAX_IN_LEN)-1:0]          cfg_last_row,
  input  logic [$clog2(MAX_OUT_LEN)-1:0]         cfg_last_col,
  input  logic [MAX_IN_LEN-1:0]                  ui_input,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]    uo_weights,
  output logic                                   uo_busy,
  output logic                                   uo_done,
  output logic                                   uo_err
);

  localparam int unsigned ROW_W = $clog2(MAX_IN_LEN);
  localparam int unsigned COL_W = $clog2(MAX_OUT_LEN);

  load_state_t              state_q;
  load_state_t              state_d;
  logic [ROW_W-1:0]         last_row_q;
  logic [COL_W-1:0]         last_col_q;
  logic [COL_W-1:0]         col_q;
  logic [MAX_IN_LEN-1:0]    msb_q;

  logic                     beat;
  logic                     start_acc;
  logic                     msb_take;
  logic                     lsb_take;
  logic                     commit_en;
  logic [2*MAX_IN_LEN-1:0]  wr_data;
  trit_t                    code;
`ifdef LOAD_CODE_CHECK_EN
  logic                     row_err;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle strobes. Abort beats any beat or commit.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    msb_take  = 1'b0;
    lsb_take  = 1'b0;
    commit_en = 1'b0;
    uo_done   = 1'b0;
    beat      = in_valid & in_ready;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = MSB;
        end
      end
      MSB: begin
        if (abort) begin
          state_d = IDLE;
        end else if (beat) begin
          msb_take = 1'b1;
          state_d  = LSB;
        end
      end
      LSB: begin
        if (abort) begin
          state_d = IDLE;
        end else if (beat) begin
          lsb_take = 1'b1;
          state_d  = (col_q == last_col_q) ? COMMIT : MSB;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (!abort) begin
          commit_en = 1'b1;
          uo_done   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control/datapath registers; ready and busy are registered from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready   <= 1'b0;
      uo_busy    <= 1'b0;
      last_row_q <= '0;
      last_col_q <= '0;
      col_q      <= '0;
      msb_q      <= '0;
    end else begin
      in_ready <= (state_d == MSB) || (state_d == LSB);
      uo_busy  <= (state_d != IDLE);
      if (start_acc) begin
        last_row_q <= cfg_last_row;
        last_col_q <= cfg_last_col;
        col_q      <= '0;
      end
      if (msb_take) begin
        msb_q <= ui_input;
      end
      if (lsb_take && (col_q != last_col_q)) begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Column write data: merge the two planes, zero rows past last_row.
  always_comb begin
    wr_data = '0;
    code    = TRIT_ZERO;
`ifdef LOAD_CODE_CHECK_EN
    row_err = 1'b0;
`endif
    for (int unsigned i = 0; i < MAX_IN_LEN; i++) begin
      code = trit_t'({msb_q[i], ui_input[i]});
      if (ROW_W'(i) <= last_row_q) begin
`ifdef LOAD_CODE_CHECK_EN
        if (trit_is_invalid(code)) begin
          row_err = 1'b1;
        end else begin
          wr_data[2*i +: 2] = code;
        end
`else
        wr_data[2*i +: 2] = code;
`endif
      end
    end
  end

`ifdef LOAD_CODE_CHECK_EN
  // Sticky error: cleared by an accepted start, set by an invalid used code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uo_err <= 1'b0;
    end else if (start_acc) begin
      uo_err <= 1'b0;
    end else if (lsb_take && row_err) begin
      uo_err <= 1'b1;
    end
  end
`else
  assign uo_err = 1'b0;
`endif

  ternary_weight_bank #(
    .ROWS (MAX_IN_LEN),
    .COLS (MAX_OUT_LEN)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (lsb_take),
    .wr_col   (col_q),
    .wr_data  (wr_data),
    .commit   (commit_en),
    .last_col (last_col_q),
    .active   (uo_weights)
  );

endmodule
